// File: rtl/alarm_pkg.sv
// Shared types and field widths for the multi-slot alarm scheduler.
package alarm_pkg;

  localparam int unsigned DAY_W    = 3;
  localparam int unsigned HOUR_W   = 4;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned TIMER_W  = 6;
  localparam int unsigned HOUR_MAX = 12;
  localparam int unsigned MIN_MAX  = 59;

  typedef enum logic [1:0] {
    StIdle,
    StRinging,
    StSnoozed
  } state_e;

  // 19-bit slot record: {en, days[6:0], pm, hour, minute}
  typedef struct packed {
    logic              en;
    logic [6:0]        days;
    logic              pm;
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  minute;
  } alarm_t;

  function automatic logic time_valid(logic [HOUR_W-1:0] hour, logic [MIN_W-1:0] minute);
    return (hour >= 4'd1) && (32'(hour) <= HOUR_MAX) && (32'(minute) <= MIN_MAX);
  endfunction

  function automatic logic [TIMER_W-1:0] sat_dec(logic [TIMER_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/multi_alarm_scheduler_if.sv
// Control/status bundle between the time counter, the scheduler and the display/sound side.
interface multi_alarm_scheduler_if #(
  parameter int unsigned NumAlarms = 7,
  parameter int unsigned IdxW      = $clog2(NumAlarms)
);
  logic                 min_tick;
  logic [2:0]           cur_day;
  logic                 cur_pm;
  logic [3:0]           cur_hour;
  logic [5:0]           cur_min;
  logic                 wr;
  logic [IdxW-1:0]      wr_idx;
  logic                 wr_en;
  logic [6:0]           wr_days;
  logic                 wr_pm;
  logic [3:0]           wr_hour;
  logic [5:0]           wr_min;
  logic                 snooze;
  logic                 stop;
  logic                 mute;
  logic                 sound;
  logic                 active;
  logic [IdxW-1:0]      active_idx;
  logic [2:0]           snooze_left;
  logic [NumAlarms-1:0] pending;
  logic                 wr_err;

  modport master (
    output min_tick, cur_day, cur_pm, cur_hour, cur_min,
    output wr, wr_idx, wr_en, wr_days, wr_pm, wr_hour, wr_min,
    output snooze, stop, mute,
    input  sound, active, active_idx, snooze_left, pending, wr_err
  );

  modport slave (
    input  min_tick, cur_day, cur_pm, cur_hour, cur_min,
    input  wr, wr_idx, wr_en, wr_days, wr_pm, wr_hour, wr_min,
    input  snooze, stop, mute,
    output sound, active, active_idx, snooze_left, pending, wr_err
  );
endinterface

// File: rtl/alarm_slot.sv
// One programmable alarm slot: storage register plus minute-tick hit comparator.
module alarm_slot
  import alarm_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  alarm_t            wdata_i,
  input  logic              min_tick_i,
  input  logic [DAY_W-1:0]  cur_day_i,
  input  logic              cur_pm_i,
  input  logic [HOUR_W-1:0] cur_hour_i,
  input  logic [MIN_W-1:0]  cur_min_i,
  output logic              hit_o
);

  alarm_t     slot_q;
  logic [7:0] days_ext;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q <= '0;
    end else if (we_i) begin
      slot_q <= wdata_i;
    end
  end

  // Day 7 does not exist; the padded zero keeps it from ever matching.
  assign days_ext = {1'b0, slot_q.days};

  assign hit_o = min_tick_i && slot_q.en && days_ext[cur_day_i] &&
                 (slot_q.pm == cur_pm_i) && (slot_q.hour == cur_hour_i) &&
                 (slot_q.minute == cur_min_i);

endmodule

// File: rtl/multi_alarm_scheduler.sv
// Multi-slot alarm scheduler: per-slot hit detection, lowest-index arbitration,
// and a ring/snooze/auto-stop controller.
module multi_alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int unsigned NumAlarms = 7,
  parameter int unsigned SnoozeMin = 5,
  parameter int unsigned MaxSnooze = 3,
  parameter int unsigned RingMin   = 10
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  multi_alarm_scheduler_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(NumAlarms);

  state_e               state_q, state_d;
  logic [IdxW-1:0]      active_idx_q, active_idx_d;
  logic [2:0]           snooze_left_q, snooze_left_d;
  logic [TIMER_W-1:0]   ring_q, ring_d;
  logic [TIMER_W-1:0]   snz_q, snz_d;
  logic [NumAlarms-1:0] pending_q, pending_d;
  logic                 wr_err_q;

  logic                 wr_ok;
  logic                 cancel;
  logic [NumAlarms-1:0] slot_we;
  logic [NumAlarms-1:0] hits;
  logic [NumAlarms-1:0] grant_mask;
  logic [IdxW-1:0]      grant_idx;
  alarm_t               wdata;

  assign wr_ok = bus.wr && time_valid(bus.wr_hour, bus.wr_min) &&
                 (32'(bus.wr_idx) < NumAlarms);

  assign wdata = '{en: bus.wr_en, days: bus.wr_days, pm: bus.wr_pm,
                   hour: bus.wr_hour, minute: bus.wr_min};

  for (genvar i = 0; i < NumAlarms; i++) begin : g_slot
    assign slot_we[i] = wr_ok && (bus.wr_idx == IdxW'(i));

    alarm_slot u_slot (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .we_i       (slot_we[i]),
      .wdata_i    (wdata),
      .min_tick_i (bus.min_tick),
      .cur_day_i  (bus.cur_day),
      .cur_pm_i   (bus.cur_pm),
      .cur_hour_i (bus.cur_hour),
      .cur_min_i  (bus.cur_min),
      .hit_o      (hits[i])
    );
  end

  always_comb begin
    grant_idx = '0;
    for (int i = NumAlarms - 1; i >= 0; i--) begin
      if (pending_q[i]) grant_idx = IdxW'(i);
    end
  end

  // Rewriting the owning slot aborts the event exactly like Stop.
  assign cancel = bus.stop || (wr_ok && (bus.wr_idx == active_idx_q));

  always_comb begin
    state_d       = state_q;
    active_idx_d  = active_idx_q;
    snooze_left_d = snooze_left_q;
    ring_d        = ring_q;
    snz_d         = snz_q;
    grant_mask    = '0;

    unique case (state_q)
      StIdle: begin
        if (pending_q != '0) begin
          state_d       = StRinging;
          active_idx_d  = grant_idx;
          grant_mask    = {{(NumAlarms - 1){1'b0}}, 1'b1} << grant_idx;
          snooze_left_d = 3'(MaxSnooze);
          ring_d        = TIMER_W'(RingMin);
        end
      end
      StRinging: begin
        if (cancel) begin
          state_d = StIdle;
        end else if (bus.snooze && (snooze_left_q != '0)) begin
          state_d       = StSnoozed;
          snooze_left_d = snooze_left_q - 3'd1;
          snz_d         = TIMER_W'(SnoozeMin);
        end else if (bus.min_tick) begin
          ring_d = sat_dec(ring_q);
          if (ring_d == '0) state_d = StIdle;
        end
      end
      StSnoozed: begin
        if (cancel) begin
          state_d = StIdle;
        end else if (bus.min_tick) begin
          snz_d = sat_dec(snz_q);
          if (snz_d == '0) begin
            state_d = StRinging;
            ring_d  = TIMER_W'(RingMin);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_q != StIdle) && (state_d == StIdle)) begin
      active_idx_d  = '0;
      snooze_left_d = '0;
      ring_d        = '0;
      snz_d         = '0;
    end

    // A write drops any stale hit for that slot, including one landing this cycle.
    pending_d = ((pending_q & ~grant_mask) | hits) & ~slot_we;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      active_idx_q  <= '0;
      snooze_left_q <= '0;
      ring_q        <= '0;
      snz_q         <= '0;
      pending_q     <= '0;
      wr_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_idx_q  <= active_idx_d;
      snooze_left_q <= snooze_left_d;
      ring_q        <= ring_d;
      snz_q         <= snz_d;
      pending_q     <= pending_d;
      wr_err_q      <= bus.wr && !wr_ok;
    end
  end

  assign bus.sound       = (state_q == StRinging) && !bus.mute;
  assign bus.active      = (state_q != StIdle);
  assign bus.active_idx  = active_idx_q;
  assign bus.snooze_left = snooze_left_q;
  assign bus.pending     = pending_q;
  assign bus.wr_err      = wr_err_q;

endmodule

// File: tb/tb_multi_alarm_scheduler.sv
// Directed bench for multi_alarm_scheduler with hand-computed expectations.
module tb_multi_alarm_scheduler;

  localparam int unsigned NumAlarms = 7;

  logic clk;
  logic rst_ni;
  int   n_checks;
  int   n_fail;

  multi_alarm_scheduler_if #(.NumAlarms(NumAlarms)) bus ();

  multi_alarm_scheduler #(
    .NumAlarms (NumAlarms),
    .SnoozeMin (5),
    .MaxSnooze (3),
    .RingMin   (10)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_slot(input logic [2:0] idx, input logic en, input logic [6:0] days,
                         input logic pm, input logic [3:0] hour, input logic [5:0] minute);
    bus.wr      = 1'b1;
    bus.wr_idx  = idx;
    bus.wr_en   = en;
    bus.wr_days = days;
    bus.wr_pm   = pm;
    bus.wr_hour = hour;
    bus.wr_min  = minute;
    step();
    bus.wr      = 1'b0;
  endtask

  task automatic tick_at(input logic [2:0] day, input logic pm, input logic [3:0] hour,
                         input logic [5:0] minute);
    bus.cur_day  = day;
    bus.cur_pm   = pm;
    bus.cur_hour = hour;
    bus.cur_min  = minute;
    bus.min_tick = 1'b1;
    step();
    bus.min_tick = 1'b0;
  endtask

  // 9:00am matches no slot programmed below.
  task automatic idle_ticks(input int n);
    for (int k = 0; k < n; k++) tick_at(3'd0, 1'b0, 4'd9, 6'd0);
  endtask

  task automatic pulse_snooze();
    bus.snooze = 1'b1;
    step();
    bus.snooze = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_ni   = 1'b0;
    bus.min_tick = 1'b0; bus.cur_day = '0; bus.cur_pm = 1'b0; bus.cur_hour = '0;
    bus.cur_min  = '0;   bus.wr = 1'b0;   bus.wr_idx = '0;    bus.wr_en = 1'b0;
    bus.wr_days  = '0;   bus.wr_pm = 1'b0; bus.wr_hour = '0;  bus.wr_min = '0;
    bus.snooze   = 1'b0; bus.stop = 1'b0; bus.mute = 1'b0;
    #1;
    chk("rst_sound", 32'(bus.sound), 0);
    chk("rst_active", 32'(bus.active), 0);
    chk("rst_idx", 32'(bus.active_idx), 0);
    chk("rst_snzleft", 32'(bus.snooze_left), 0);
    chk("rst_pending", 32'(bus.pending), 0);
    chk("rst_wrerr", 32'(bus.wr_err), 0);
    step();
    rst_ni = 1'b1;
    step();

    // Single slot, Monday 7:30am
    wr_slot(3'd2, 1'b1, 7'b0000010, 1'b0, 4'd7, 6'd30);
    chk("t1_wrerr_ok", 32'(bus.wr_err), 0);
    tick_at(3'd2, 1'b0, 4'd7, 6'd30);
    chk("t1_wrong_day", 32'(bus.pending), 0);
    tick_at(3'd1, 1'b0, 4'd7, 6'd30);
    chk("t1_pending", 32'(bus.pending), 32'b0000100);
    chk("t1_no_sound_yet", 32'(bus.sound), 0);
    step();
    chk("t1_sound", 32'(bus.sound), 1);
    chk("t1_idx", 32'(bus.active_idx), 2);
    chk("t1_snzleft", 32'(bus.snooze_left), 3);
    chk("t1_pend_clr", 32'(bus.pending), 0);
    pulse_stop();
    chk("t1_stopped", 32'(bus.active), 0);

    // Two slots hit together, lowest index served first
    wr_slot(3'd1, 1'b1, 7'h7f, 1'b1, 4'd6, 6'd0);
    wr_slot(3'd4, 1'b1, 7'h7f, 1'b1, 4'd6, 6'd0);
    tick_at(3'd3, 1'b1, 4'd6, 6'd0);
    chk("t2_pending", 32'(bus.pending), 32'b0010010);
    step();
    chk("t2_idx1", 32'(bus.active_idx), 1);
    chk("t2_pend4", 32'(bus.pending), 32'b0010000);
    pulse_stop();
    chk("t2_idle_between", 32'(bus.active), 0);
    step();
    chk("t2_idx4", 32'(bus.active_idx), 4);
    chk("t2_sound4", 32'(bus.sound), 1);
    chk("t2_pend0", 32'(bus.pending), 0);
    pulse_stop();
    chk("t2_done", 32'(bus.active), 0);
    chk("t2_done_pend", 32'(bus.pending), 0);

    // Snooze cycle on slot 0 at 8:15am
    wr_slot(3'd0, 1'b1, 7'h7f, 1'b0, 4'd8, 6'd15);
    tick_at(3'd0, 1'b0, 4'd8, 6'd15);
    step();
    chk("t3_ring", 32'(bus.sound), 1);
    pulse_snooze();
    chk("t3_snz_sound", 32'(bus.sound), 0);
    chk("t3_snz_active", 32'(bus.active), 1);
    chk("t3_snz_left2", 32'(bus.snooze_left), 2);
    idle_ticks(2);
    pulse_snooze();
    chk("t3_snz_ignored", 32'(bus.snooze_left), 2);
    idle_ticks(2);
    chk("t3_still_snz", 32'(bus.sound), 0);
    idle_ticks(1);
    chk("t3_rering1", 32'(bus.sound), 1);
    chk("t3_rering1_left", 32'(bus.snooze_left), 2);
    pulse_snooze();
    idle_ticks(5);
    chk("t3_rering2_left", 32'(bus.snooze_left), 1);
    pulse_snooze();
    idle_ticks(5);
    chk("t3_rering3", 32'(bus.sound), 1);
    chk("t3_rering3_left", 32'(bus.snooze_left), 0);
    pulse_snooze();
    chk("t3_snz_exhausted", 32'(bus.sound), 1);
    idle_ticks(9);
    chk("t3_before_auto", 32'(bus.active), 1);
    idle_ticks(1);
    chk("t3_autostop", 32'(bus.active), 0);

    // Rejected writes leave slot 0 intact
    wr_slot(3'd0, 1'b1, 7'h7f, 1'b0, 4'd13, 6'd0);
    chk("t4_err_hour13", 32'(bus.wr_err), 1);
    wr_slot(3'd0, 1'b1, 7'h7f, 1'b0, 4'd8, 6'd60);
    chk("t4_err_min60", 32'(bus.wr_err), 1);
    wr_slot(3'd0, 1'b0, 7'h7f, 1'b0, 4'd0, 6'd15);
    chk("t4_err_hour0", 32'(bus.wr_err), 1);
    wr_slot(3'd7, 1'b1, 7'h7f, 1'b0, 4'd9, 6'd0);
    chk("t4_err_idx7", 32'(bus.wr_err), 1);
    step();
    chk("t4_err_pulse_end", 32'(bus.wr_err), 0);
    idle_ticks(1);
    chk("t4_idx7_not_written", 32'(bus.pending), 0);
    tick_at(3'd5, 1'b0, 4'd8, 6'd15);
    chk("t4_slot0_intact", 32'(bus.pending), 1);
    step();
    chk("t4_ring0", 32'(bus.active_idx), 0);
    chk("t4_ring0_active", 32'(bus.active), 1);

    // Mute silences only the buzzer; ring timer keeps counting
    bus.mute = 1'b1;
    #1;
    chk("t5_mute_sound", 32'(bus.sound), 0);
    chk("t5_mute_active", 32'(bus.active), 1);
    idle_ticks(3);
    bus.mute = 1'b0;
    #1;
    chk("t5_unmute", 32'(bus.sound), 1);
    idle_ticks(6);
    chk("t5_pre_auto", 32'(bus.active), 1);
    idle_ticks(1);
    chk("t5_auto", 32'(bus.active), 0);

    // Stop and Snooze together: Stop wins
    tick_at(3'd5, 1'b0, 4'd8, 6'd15);
    step();
    bus.stop   = 1'b1;
    bus.snooze = 1'b1;
    step();
    bus.stop   = 1'b0;
    bus.snooze = 1'b0;
    chk("t5_stop_wins", 32'(bus.active), 0);
    chk("t5_stop_left", 32'(bus.snooze_left), 0);

    // Rewriting the ringing slot cancels the event
    tick_at(3'd5, 1'b0, 4'd8, 6'd15);
    step();
    chk("t5_ring_again", 32'(bus.active), 1);
    wr_slot(3'd0, 1'b1, 7'h7f, 1'b0, 4'd8, 6'd15);
    chk("t5_wr_cancel", 32'(bus.active), 0);

    // Async reset mid-snooze wipes slots
    tick_at(3'd1, 1'b0, 4'd7, 6'd30);
    step();
    pulse_snooze();
    chk("t6_snoozed_idx", 32'(bus.active_idx), 2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_active", 32'(bus.active), 0);
    chk("t6_rst_idx", 32'(bus.active_idx), 0);
    chk("t6_rst_left", 32'(bus.snooze_left), 0);
    chk("t6_rst_pending", 32'(bus.pending), 0);
    step();
    rst_ni = 1'b1;
    step();
    tick_at(3'd1, 1'b0, 4'd7, 6'd30);
    chk("t6_slot_cleared", 32'(bus.pending), 0);
    step();
    chk("t6_no_ring", 32'(bus.active), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
